// File: rtl/spikeout_gen_pkg.sv
// Shared types and default sizing for the spike output generator.
package spikeout_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int unsigned NUM_DEFAULT    = 10;
  localparam int unsigned WINDOW_DEFAULT = 16;

endpackage

// File: rtl/spikeout_gen_prio_enc.sv
// Lowest-index one-hot priority selector over a [p_num:1] request vector.
module spike_prio_enc #(
  parameter int unsigned p_num = 10
) (
  input  logic [p_num:1] req,
  output logic [p_num:1] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= p_num; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spikeout_gen.sv
// Arms a capture window on i_spike_in and emits one registered one-hot pulse for
// the lowest-index neuron spike seen before the window times out.
module spikeout_gen
  import spikeout_gen_pkg::*;
#(
  parameter int unsigned p_num    = NUM_DEFAULT,
  parameter int unsigned p_window = WINDOW_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_spike_in,
  input  logic [p_num:1] i_spike,
  output logic [p_num:1] o_spike
);

  localparam int unsigned CW = $clog2(p_window + 1);
  localparam logic [CW-1:0] WIN = CW'(p_window);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [p_num:1]  sel;

  spike_prio_enc #(.p_num(p_num)) u_prio_enc (
    .req   (i_spike),
    .grant (sel)
  );

  // Window of p_window armed cycles; the last one drops back to IDLE directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      o_spike <= '0;
    end else begin
      o_spike <= '0;
      case (state)
        IDLE: begin
          if (i_spike_in) begin
            state <= ARMED;
            cnt   <= WIN;
          end
        end
        ARMED: begin
          if (|i_spike) begin
            o_spike <= sel;
            state   <= IDLE;
            cnt     <= '0;
          end else if (i_spike_in) begin
            cnt <= WIN;
          end else if (cnt <= CW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spikeout_gen.sv
// Bench for spikeout_gen: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a deadline-based model.
module tb_spikeout_gen;

  localparam int N = 10;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         spike_in;
  logic [N:1]   spike;
  logic [N:1]   o_spike;

  int compared   = 0;
  int mismatched = 0;

  spikeout_gen #(.p_num(N), .p_window(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_spike_in (spike_in),
    .i_spike    (spike),
    .o_spike    (o_spike)
  );

  always #5 clk = ~clk;

  // Model: armed flag plus the absolute cycle number of the last armed cycle.
  bit         m_armed = 1'b0;
  longint     cyc     = 0;
  longint     m_end   = 0;
  logic [N:1] m_exp   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_armed = 1'b0;
      m_exp   = '0;
    end else begin
      m_exp = '0;
      if (m_armed) begin
        if (spike != '0) begin
          m_exp   = spike & (~spike + 1'b1);
          m_armed = 1'b0;
        end else if (spike_in) begin
          m_end = cyc + W;
        end else if (cyc == m_end) begin
          m_armed = 1'b0;
        end
      end else if (spike_in) begin
        m_armed = 1'b1;
        m_end   = cyc + W;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    compared++;
    if (o_spike !== m_exp) begin
      mismatched++;
      $display("FAIL model_cmp t=%0t o_spike=%h expected=%h", $time, o_spike, m_exp);
    end
    compared++;
    if ($countones(o_spike) > 1) begin
      mismatched++;
      $display("FAIL onehot t=%0t o_spike=%h expected at most one bit", $time, o_spike);
    end
  end

  task automatic drive(input logic si, input logic [N:1] sp);
    spike_in = si;
    spike    = sp;
    @(posedge clk);
    #1;
    spike_in = 1'b0;
    spike    = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic check(input string name, input logic [N:1] exp);
    compared++;
    if (o_spike !== exp) begin
      mismatched++;
      $display("FAIL %s o_spike=%h expected=%h", name, o_spike, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async", '0);
    @(posedge clk);
    #1;
    check("reset_hold", '0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    spike_in = 1'b0;
    spike    = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic capture, one cycle latency, single-cycle pulse
    drive(1'b1, '0);
    idle(2);
    drive(1'b0, 10'h040);
    check("basic_pulse", 10'h040);
    drive(1'b0, '0);
    check("basic_clear", '0);

    // Second event in same neuron after capture is ignored
    drive(1'b1, '0);
    drive(1'b0, 10'h080);
    check("once_pulse", 10'h080);
    idle(7);
    drive(1'b0, 10'h080);
    check("once_ignored", '0);

    // Later event on another neuron ignored
    drive(1'b1, '0);
    drive(1'b0, 10'h200);
    check("first_only", 10'h200);
    idle(2);
    drive(1'b0, 10'h002);
    check("second_ignored", '0);

    // Timeout after W silent armed cycles
    drive(1'b1, '0);
    idle(W);
    drive(1'b0, 10'h040);
    check("timeout", '0);

    // Last cycle of the window still captures
    drive(1'b1, '0);
    idle(W - 1);
    drive(1'b0, 10'h001);
    check("window_edge", 10'h001);

    // Lowest index wins
    drive(1'b1, '0);
    drive(1'b0, 10'h2C0);
    check("prio_2c0", 10'h040);
    drive(1'b1, '0);
    drive(1'b1, 10'h006);
    check("capture_beats_rearm", 10'h002);
    drive(1'b0, 10'h008);
    check("rearm_discarded", '0);

    // Event in arming cycle ignored, next cycle captures
    drive(1'b1, 10'h004);
    check("arm_cycle_ignored", '0);
    drive(1'b0, 10'h004);
    check("post_arm_capture", 10'h004);

    // Window restart
    drive(1'b1, '0);
    idle(W - 1);
    drive(1'b1, '0);
    idle(W - 1);
    drive(1'b0, 10'h001);
    check("restart", 10'h001);

    // Reset mid-window aborts it
    drive(1'b1, '0);
    idle(2);
    do_reset();
    drive(1'b0, 10'h040);
    check("reset_abort", '0);
    idle(3);
    check("reset_abort_quiet", '0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      automatic int unsigned phase = (i / 400) % 3;
      automatic int unsigned sp_div = (phase == 0) ? 4 : (phase == 1) ? 12 : 40;
      automatic logic [N:1] sp = '0;
      if ($urandom_range(sp_div - 1) == 0) sp = N'($urandom);
      if ($urandom_range(799) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(9) == 0), sp);
      end
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spikeout_gen.md
SPIKEOUT_GEN -- requirements
Module: spikeout_gen

Interface
REQ-001 Parameter p_num, default 10: number of neuron spike lines; SHALL be at least 1.
REQ-002 Parameter p_window, default 16: arming window length in clock cycles; SHALL be at least 1.
REQ-003 i_clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1: reset, asynchronous, active-low.
REQ-005 i_spike_in  input  1: input-spike strobe (one cycle high); it opens a capture window.
REQ-006 i_spike  input  [p_num:1]: per-neuron spike events, one-cycle pulses; index 1 is the lowest.
REQ-007 o_spike  output  [p_num:1]: registered one-hot output spike, one-cycle pulse.

Function
REQ-008 Two states SHALL exist: IDLE (disarmed) and ARMED (window open).
REQ-009 In IDLE, a cycle with i_spike_in=1 SHALL move the block to ARMED on the next edge and load the window counter with p_window.
REQ-010 In IDLE, i_spike SHALL be ignored and o_spike SHALL be 0.
REQ-011 In ARMED, the first cycle with i_spike != 0 SHALL register o_spike one-hot at the lowest set index, valid in the following cycle only.
REQ-012 That capture cycle SHALL also return the block to IDLE, so each window produces at most one output pulse.
REQ-013 Simultaneous events in ARMED SHALL resolve to the lowest index; example: i_spike=10'h006 gives o_spike=10'h002.
REQ-014 In ARMED with i_spike=0, the counter SHALL decrement by one per cycle.
REQ-015 When the counter reaches 0 in ARMED, the block SHALL return to IDLE with no output pulse (timeout).
REQ-016 i_spike_in=1 while ARMED with i_spike=0 SHALL reload the counter to p_window and stay ARMED (window restart).
REQ-017 i_spike_in=1 and i_spike!=0 in the same ARMED cycle: the capture SHALL win; the block outputs the pulse and goes to IDLE, and that i_spike_in is discarded.
REQ-018 i_spike!=0 in the same cycle that i_spike_in arms from IDLE SHALL be ignored; capture starts the next cycle.
REQ-019 o_spike latency SHALL be exactly 1 cycle from the sampled i_spike event; o_spike SHALL never have more than one bit set.
REQ-020 Counter width SHALL be clog2(p_window+1) bits; the counter SHALL saturate at 0 and never wrap.

Reset
REQ-021 i_rst_n=0 SHALL asynchronously force state IDLE, counter 0 and o_spike 0.
REQ-022 A reset asserted mid-window SHALL abort the window; no pulse is emitted after reset release until a new i_spike_in arrives.
REQ-023 Reset release SHALL be synchronous to i_clk; the first i_spike_in is accepted on the first edge after release.

Structure
REQ-024 A shared package SHALL hold the state enumeration (IDLE, ARMED) and the default p_num and p_window constants.
REQ-025 One sub-module, spike_prio_enc, SHALL implement the parameterized lowest-index one-hot priority selector over p_num bits.
REQ-026 The top level SHALL contain only the state register, the window counter and the output register.

Verification
REQ-027 Reset, then i_spike_in pulse, 3 cycles later i_spike=10'h040 -> o_spike=10'h040 for exactly one cycle, one cycle after the event.
REQ-028 i_spike_in, then 10'h080, then 10'h080 again 8 cycles later -> exactly one pulse 10'h080; the second event is ignored.
REQ-029 i_spike_in, then 10'h200, then 10'h002 later -> only 10'h200 is output.
REQ-030 i_spike_in with no event for p_window cycles, then 10'h040 -> no output pulse (timeout).
REQ-031 i_spike_in, then i_spike=10'h2C0 -> o_spike=10'h040 (lowest index wins).
REQ-032 i_rst_n asserted between i_spike_in and the event -> o_spike stays 0 throughout.
